// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM encoding,
// default timing constants and a counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_NUM_KEYS   = 2;
  localparam int unsigned DEF_DB_CYCLES  = 1048576;
  localparam int unsigned DEF_RPT_DELAY  = 16777216;
  localparam int unsigned DEF_RPT_PERIOD = 4194304;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One debounced key: 2-flop synchronizer, debounce FSM, auto-repeat counter
// and registered level/press/release outputs.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic rpt_en,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned DW  = cnt_width(DB_CYCLES);
  localparam int unsigned RPW = cnt_width(RPT_DELAY);
  localparam logic [DW-1:0]  DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0] RPT_LAST   = RPW'(RPT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes later repeats land PERIOD cycles apart.
  localparam logic [RPW-1:0] RPT_RELOAD = RPW'(RPT_DELAY - RPT_PERIOD);

  logic           sync_q1;
  logic           s;
  key_state_e     state_q, state_d;
  logic [DW-1:0]  db_q, db_d;
  logic [RPW-1:0] rpt_q, rpt_d;
  logic           press_d, release_d;

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          db_d    = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          rpt_d   = '0;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          db_d    = '0;
        end else if (!rpt_en) begin
          rpt_d = '0;
        end else if (rpt_q == RPT_LAST) begin
          press_d = 1'b1;
          rpt_d   = RPT_RELOAD;
        end else begin
          rpt_d = rpt_q + RPW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // Repeat counter stays frozen here; bouncing back restarts repeat timing.
        if (s) begin
          state_d = ST_HELD;
          rpt_d   = '0;
        end else if (db_q == DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1     <= 1'b0;
      s           <= 1'b0;
      state_q     <= ST_IDLE;
      db_q        <= '0;
      rpt_q       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q1     <= key_raw;
      s           <= sync_q1;
      state_q     <= state_d;
      db_q        <= db_d;
      rpt_q       <= rpt_d;
      key_level   <= (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer with per-key auto-repeat; one independent key_channel
// per input bit.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = DEF_NUM_KEYS,
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_KEYS-1:0] rpt_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw[g]),
      .rpt_en     (rpt_en[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing (DB=8, delay=32, period=8);
// pulse times are logged relative to the stimulus edge and compared to hand values.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key_raw = '0;
  logic [1:0] rpt_en  = '0;
  logic [1:0] key_level, key_press, key_release;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int p0[$], p1[$], r0[$], r1[$];
  bit both_seen = 1'b0;

  key_debounce #(
    .NUM_KEYS  (2),
    .DB_CYCLES (8),
    .RPT_DELAY (32),
    .RPT_PERIOD(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .rpt_en     (rpt_en),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_press[0] === 1'b1)   p0.push_back(cyc);
    if (key_press[1] === 1'b1)   p1.push_back(cyc);
    if (key_release[0] === 1'b1) r0.push_back(cyc);
    if (key_release[1] === 1'b1) r1.push_back(cyc);
    if ((key_press & key_release) != 2'b00) both_seen = 1'b1;
  end

  function automatic string q2s(input int q[$], input int base);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i] - base)};
    return s;
  endfunction

  task automatic clear_logs();
    p0.delete(); p1.delete(); r0.delete(); r1.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_raw = '0; rpt_en = '0;
    idle(3);
    tests++; if (key_level !== 2'b00) begin fails++; $display("FAIL reset_level: got %b expected 00", key_level); end
    tests++; if (key_press !== 2'b00) begin fails++; $display("FAIL reset_press: got %b expected 00", key_press); end
    tests++; if (key_release !== 2'b00) begin fails++; $display("FAIL reset_release: got %b expected 00", key_release); end
    rst = 1'b1;
    idle(3);
    tests++; if (key_level !== 2'b00) begin fails++; $display("FAIL post_reset_level: got %b expected 00", key_level); end
  endtask

  task automatic test_clean_press();
    int t0, t1;
    clear_logs();
    key_raw[0] = 1'b1; t0 = cyc;
    idle(10);
    tests++; if (key_level[0] !== 1'b0) begin fails++; $display("FAIL clean_level_early: got %b expected 0", key_level[0]); end
    idle(1);
    tests++; if (key_press[0] !== 1'b1 || key_level[0] !== 1'b1) begin fails++; $display("FAIL clean_at_11: got press=%b level=%b expected 1 1", key_press[0], key_level[0]); end
    idle(9);
    tests++; if (q2s(p0, t0) != "11 ") begin fails++; $display("FAIL clean_press_times: got '%s' expected '11 '", q2s(p0, t0)); end
    tests++; if (p1.size() != 0 || r0.size() != 0) begin fails++; $display("FAIL clean_no_other: got p1=%0d r0=%0d expected 0 0", p1.size(), r0.size()); end
    key_raw[0] = 1'b0; t1 = cyc;
    idle(20);
    tests++; if (q2s(r0, t1) != "11 ") begin fails++; $display("FAIL clean_release_times: got '%s' expected '11 '", q2s(r0, t1)); end
    tests++; if (key_level[0] !== 1'b0) begin fails++; $display("FAIL clean_level_after_release: got %b expected 0", key_level[0]); end
  endtask

  task automatic test_bounce();
    int t0;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      key_raw[0] = (i % 2 == 0);
      idle(4);
    end
    key_raw[0] = 1'b1; t0 = cyc;
    idle(20);
    tests++; if (q2s(p0, t0) != "11 ") begin fails++; $display("FAIL bounce_press_times: got '%s' expected '11 '", q2s(p0, t0)); end
    tests++; if (key_level[0] !== 1'b1) begin fails++; $display("FAIL bounce_level: got %b expected 1", key_level[0]); end
    key_raw[0] = 1'b0;
    idle(20);
  endtask

  task automatic test_repeat(input bit en, input string expect_p);
    int t0;
    clear_logs();
    rpt_en = {en, 1'b0};
    key_raw[1] = 1'b1; t0 = cyc;
    idle(80);
    key_raw[1] = 1'b0;
    idle(20);
    tests++; if (q2s(p1, t0) != expect_p) begin fails++; $display("FAIL repeat_en%0d_press: got '%s' expected '%s'", en, q2s(p1, t0), expect_p); end
    tests++; if (q2s(r1, t0) != "91 ") begin fails++; $display("FAIL repeat_en%0d_release: got '%s' expected '91 '", en, q2s(r1, t0)); end
    tests++; if (p0.size() != 0 || r0.size() != 0) begin fails++; $display("FAIL repeat_en%0d_key0_quiet: got p0=%0d r0=%0d expected 0 0", en, p0.size(), r0.size()); end
    rpt_en = '0;
  endtask

  task automatic test_glitch();
    int t0;
    clear_logs();
    rpt_en = 2'b01;
    key_raw[0] = 1'b1; t0 = cyc;
    idle(20);
    key_raw[0] = 1'b0;
    idle(3);
    key_raw[0] = 1'b1;
    idle(2);
    tests++; if (key_level[0] !== 1'b1) begin fails++; $display("FAIL glitch_level: got %b expected 1", key_level[0]); end
    idle(45);
    key_raw[0] = 1'b0;
    idle(20);
    tests++; if (q2s(p0, t0) != "11 58 66 ") begin fails++; $display("FAIL glitch_press_times: got '%s' expected '11 58 66 '", q2s(p0, t0)); end
    tests++; if (q2s(r0, t0) != "81 ") begin fails++; $display("FAIL glitch_release_times: got '%s' expected '81 '", q2s(r0, t0)); end
    rpt_en = '0;
  endtask

  task automatic test_reset_mid_held();
    int t0;
    clear_logs();
    key_raw[0] = 1'b1;
    idle(20);
    tests++; if (key_level[0] !== 1'b1) begin fails++; $display("FAIL midreset_pre_level: got %b expected 1", key_level[0]); end
    rst = 1'b0;
    #1;
    tests++; if (key_level !== 2'b00 || key_press !== 2'b00) begin fails++; $display("FAIL midreset_async: got level=%b press=%b expected 00 00", key_level, key_press); end
    clear_logs();
    idle(3);
    rst = 1'b1; t0 = cyc;
    idle(20);
    tests++; if (q2s(p0, t0) != "11 ") begin fails++; $display("FAIL midreset_repress: got '%s' expected '11 '", q2s(p0, t0)); end
    tests++; if (r0.size() != 0) begin fails++; $display("FAIL midreset_no_release: got %0d expected 0", r0.size()); end
    key_raw[0] = 1'b0;
    idle(20);
  endtask

  task automatic test_simultaneous();
    int t0;
    clear_logs();
    key_raw = 2'b11; t0 = cyc;
    idle(20);
    key_raw[0] = 1'b0;
    idle(5);
    key_raw[1] = 1'b0;
    idle(20);
    tests++; if (q2s(p0, t0) != "11 " || q2s(p1, t0) != "11 ") begin fails++; $display("FAIL simul_press: got '%s'/'%s' expected '11 '/'11 '", q2s(p0, t0), q2s(p1, t0)); end
    tests++; if (q2s(r0, t0) != "31 ") begin fails++; $display("FAIL simul_release0: got '%s' expected '31 '", q2s(r0, t0)); end
    tests++; if (q2s(r1, t0) != "36 ") begin fails++; $display("FAIL simul_release1: got '%s' expected '36 '", q2s(r1, t0)); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat(1'b1, "11 43 51 59 67 75 ");
    test_repeat(1'b0, "11 ");
    test_glitch();
    test_reset_mid_held();
    test_simultaneous();
    tests++; if (both_seen) begin fails++; $display("FAIL press_release_overlap: got 1 expected 0"); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
